ps2_direction_decoder: RTL and testbench

//  Receives PS/2 keyboard frames and turns scancodes into the move_up/down/left/right level inputs consumed by the snake
//  VGA controller. Covers the input end of that control interface: it produces direction levels, and the controller reads them.

---
 rtl/ps2_direction_decoder_pkg.sv | 56 +++++
 rtl/ps2_direction_decoder_if.sv | 9 +
 rtl/ps2_direction_decoder_rx_frame.sv | 126 ++++++++++++
 rtl/ps2_direction_decoder.sv | 83 ++++++++
 tb/tb_ps2_direction_decoder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_direction_decoder_pkg.sv
// Shared types and scancode constants for the PS/2 direction decoder.
// Arrow keys arrive behind the E0 prefix; WASD keys arrive as plain codes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;

  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_D = 8'h23;

  // One-hot direction mask for a byte; bit index is dir_t.
  function automatic logic [3:0] key_mask(input logic [7:0] code, input logic ext);
    logic [3:0] m;
    m = '0;
    if (ext) begin
      case (code)
        SC_ARROW_UP:    m[DIR_UP]    = 1'b1;
        SC_ARROW_DOWN:  m[DIR_DOWN]  = 1'b1;
        SC_ARROW_LEFT:  m[DIR_LEFT]  = 1'b1;
        SC_ARROW_RIGHT: m[DIR_RIGHT] = 1'b1;
        default:        m = '0;
      endcase
    end else begin
      case (code)
        SC_W:    m[DIR_UP]    = 1'b1;
        SC_S:    m[DIR_DOWN]  = 1'b1;
        SC_A:    m[DIR_LEFT]  = 1'b1;
        SC_D:    m[DIR_RIGHT] = 1'b1;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_direction_decoder_if.sv
// Received-byte link between the PS/2 frame receiver and the scancode parser.
interface ps2_direction_decoder_if;
  logic [7:0] scan;
  logic       scan_valid;
  logic       frame_err;

  modport master (output scan, output scan_valid, output frame_err);
  modport slave  (input  scan, input  scan_valid, input  frame_err);
endinterface

// File: rtl/ps2_direction_decoder_rx_frame.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, start/data/parity/stop
// FSM with mid-frame timeout. Emits one byte strobe or one error strobe per frame.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  ps2_direction_decoder_if.master rx
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   sync_clk;
  logic                   sync_dat;
  logic                   sync_clk_prev;
  logic                   fall;

  rx_state_t  state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [7:0] scan_q, scan_n;
  logic       valid_q, valid_n;
  logic       err_q, err_n;

  // Idle PS/2 lines are high; resetting the chain high avoids a false fall after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync      <= '1;
      dat_sync      <= '1;
      sync_clk_prev <= 1'b1;
      fall          <= 1'b0;
    end else begin
      clk_sync      <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync      <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      sync_clk_prev <= sync_clk;
      fall          <= sync_clk_prev & ~sync_clk;
    end
  end

  assign sync_clk = clk_sync[SYNC_STAGES-1];
  assign sync_dat = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
      scan_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      par     <= par_n;
      tcnt    <= tcnt_n;
      scan_q  <= scan_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    par_n   = par;
    tcnt_n  = tcnt;
    scan_n  = scan_q;
    valid_n = 1'b0;
    err_n   = 1'b0;

    if (state == IDLE || fall) tcnt_n = '0;
    else                       tcnt_n = tcnt + TW'(1);

    if (fall) begin
      case (state)
        IDLE: begin
          if (!sync_dat) begin
            state_n = DATA;
            cnt_n   = '0;
          end
        end
        DATA: begin
          shreg_n = {sync_dat, shreg[7:1]};
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = sync_dat;
          state_n = STOP;
        end
        STOP: begin
          if ((^{shreg, par}) && sync_dat) begin
            scan_n  = shreg;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tcnt == TW'(TIMEOUT)) begin
      state_n = IDLE;
      tcnt_n  = '0;
      err_n   = 1'b1;
    end
  end

  assign rx.scan       = scan_q;
  assign rx.scan_valid = valid_q;
  assign rx.frame_err  = err_q;

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard to snake direction levels: frame receiver plus E0/F0-aware
// scancode parser driving four held-key levels (arrows and WASD share levels).
module ps2_direction_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 5000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic [7:0] oSCAN,
  output logic       oSCAN_VALID,
  output logic       oFRAME_ERR,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right
);

  ps2_direction_decoder_if link ();

  ps2_rx_frame #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) u_rx (
    .clk     (iCLK),
    .rst     (iRST),
    .ps2_clk (iPS2_CLK),
    .ps2_dat (iPS2_DAT),
    .rx      (link)
  );

  logic       ext, ext_n;
  logic       brk, brk_n;
  logic [3:0] dir, dir_n;
  logic [3:0] mask;

  assign mask = key_mask(link.scan, ext);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ext <= 1'b0;
      brk <= 1'b0;
      dir <= '0;
    end else begin
      ext <= ext_n;
      brk <= brk_n;
      dir <= dir_n;
    end
  end

  // Any non-prefix byte ends the prefix sequence, matched or not.
  always_comb begin
    ext_n = ext;
    brk_n = brk;
    dir_n = dir;
    if (link.frame_err) begin
      ext_n = 1'b0;
      brk_n = 1'b0;
    end else if (link.scan_valid) begin
      if (link.scan == SC_BRK) begin
        brk_n = 1'b1;
      end else if (link.scan == SC_EXT) begin
        ext_n = 1'b1;
      end else begin
        dir_n = brk ? (dir & ~mask) : (dir | mask);
        ext_n = 1'b0;
        brk_n = 1'b0;
      end
    end
  end

  assign oSCAN       = link.scan;
  assign oSCAN_VALID = link.scan_valid;
  assign oFRAME_ERR  = link.frame_err;
  assign move_up     = dir[DIR_UP];
  assign move_down   = dir[DIR_DOWN];
  assign move_left   = dir[DIR_LEFT];
  assign move_right  = dir[DIR_RIGHT];

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder: bit-banged PS/2 frames, negedge monitor.
module tb_ps2_direction_decoder;

  localparam int unsigned TO   = 200;
  localparam int          HALF = 20;
  localparam int          CLK_P = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic move_up, move_down, move_left, move_right;
  logic [3:0] dirs;

  ps2_direction_decoder_if mon ();

  ps2_direction_decoder #(
    .SYNC_STAGES (2),
    .TIMEOUT     (TO)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iPS2_CLK    (ps2_clk),
    .iPS2_DAT    (ps2_dat),
    .oSCAN       (mon.scan),
    .oSCAN_VALID (mon.scan_valid),
    .oFRAME_ERR  (mon.frame_err),
    .move_up     (move_up),
    .move_down   (move_down),
    .move_left   (move_left),
    .move_right  (move_right)
  );

  always #5 clk = ~clk;

  assign dirs = {move_up, move_down, move_left, move_right};

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  time last_fall_t = 0;
  time stop_fall_t = 0;
  time last_valid_t = 0;
  time last_err_t = 0;
  logic [3:0] dir_at_valid = '0;
  logic [3:0] dir_after_valid = '0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (prev_valid) dir_after_valid = dirs;
    if (mon.scan_valid === 1'b1) begin
      valid_cnt++;
      last_valid_t = $time;
      dir_at_valid = dirs;
    end
    if (mon.frame_err === 1'b1) begin
      err_cnt++;
      last_err_t = $time;
    end
    prev_valid = (mon.scan_valid === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    ps2_dat = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_t = $time;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ par_flip);
    send_bit(stop_v);
    stop_fall_t = last_fall_t;
    ps2_dat = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  int v0, e0;
  time t_last;
  int lat;
  logic [7:0] partial;

  initial begin
    repeat (5) @(negedge clk);
    check("rst_scan", {24'd0, mon.scan}, 32'h00);
    check("rst_valid", {31'd0, mon.scan_valid}, 0);
    check("rst_err", {31'd0, mon.frame_err}, 0);
    check("rst_dirs", {28'd0, dirs}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 1. clean W frame
    v0 = valid_cnt; e0 = err_cnt;
    send_key(8'h1D);
    check("t1_scan", {24'd0, mon.scan}, 32'h1D);
    check("t1_valid_cnt", valid_cnt - v0, 1);
    check("t1_valid_lat", 32'((last_valid_t - stop_fall_t) / CLK_P), 4);
    check("t1_dirs", {28'd0, dirs}, 32'b1000);

    // 2. arrow make (typematic on held level), then extended break
    send_key(8'hE0); send_key(8'h75);
    check("t2_up_make", {28'd0, dirs}, 32'b1000);
    send_key(8'hE0); send_key(8'hF0); send_key(8'h75);
    check("t2_scan", {24'd0, mon.scan}, 32'h75);
    check("t2_up_at_valid", {31'd0, dir_at_valid[3]}, 1);
    check("t2_up_after", {31'd0, dir_after_valid[3]}, 0);
    check("t2_no_err", err_cnt - e0, 0);
    check("t2_valid_cnt", valid_cnt - v0, 6);
    // E0 1D is not a WASD key
    send_key(8'hE0); send_key(8'h1D);
    check("t2_e0_1d_ignored", {28'd0, dirs}, 0);

    // 3. parity error, then extended right
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h23, 1'b1, 1'b1);
    check("t3_err_cnt", err_cnt - e0, 1);
    check("t3_valid_cnt", valid_cnt - v0, 0);
    check("t3_dirs", {28'd0, dirs}, 0);
    send_key(8'hE0); send_key(8'h74);
    check("t3_right", {28'd0, dirs}, 32'b0001);
    send_key(8'hF0); send_key(8'h23);
    check("t3_shared_break", {28'd0, dirs}, 0);
    // stop error after E0 must clear ext so plain 23 matches D
    e0 = err_cnt;
    send_key(8'hE0);
    send_frame(8'h1D, 1'b0, 1'b0);
    check("t3_stop_err", err_cnt - e0, 1);
    send_key(8'h23);
    check("t3_ext_cleared", {28'd0, dirs}, 32'b0001);
    send_key(8'hF0); send_key(8'h23);
    check("t3_right_off", {28'd0, dirs}, 0);

    // 4. timeout mid-frame
    e0 = err_cnt;
    partial = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i]);
    t_last = last_fall_t;
    ps2_dat = 1'b1;
    repeat (TO + 20) @(negedge clk);
    check("t4_err_cnt", err_cnt - e0, 1);
    lat = int'((last_err_t - t_last) / CLK_P);
    check("t4_err_lat", {31'd0, (lat >= int'(TO) && lat <= int'(TO) + 6)}, 1);
    send_key(8'h1C);
    check("t4_left", {28'd0, dirs}, 32'b0010);

    // 5. simultaneous keys
    send_key(8'h1B);
    check("t5_left_down", {28'd0, dirs}, 32'b0110);
    send_key(8'hF0); send_key(8'h1C);
    check("t5_down_only", {28'd0, dirs}, 32'b0100);

    // 6. async reset mid-frame
    send_key(8'h1D);
    check("t6_pre", {28'd0, dirs}, 32'b1100);
    partial = 8'h1D;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(partial[i]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_dirs", {28'd0, dirs}, 0);
    check("t6_rst_scan", {24'd0, mon.scan}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ps2_dat = 1'b1;
    repeat (10) @(negedge clk);
    e0 = err_cnt;
    send_key(8'h1D);
    check("t6_scan", {24'd0, mon.scan}, 32'h1D);
    check("t6_dirs", {28'd0, dirs}, 32'b1000);
    check("t6_no_err", err_cnt - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
